// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port sequencer: FSM states and mux select polarity.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie, the side not served last wins.
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_a,
    output logic pick_a,
    output logic any
);

    assign any    = req_a | req_b;
    assign pick_a = req_a & (~req_b | ~last_a);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer: arbitrates LSU (A) vs fetch (B), strobes the memory once,
// and times the fixed read latency to return a completion pulse to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic done_a,
    output logic done_b,
    output logic sel,
    output logic mem_en,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             last_a, last_a_nx;
    logic             sel_nx, gnt_a_nx, gnt_b_nx, done_a_nx, done_b_nx, mem_en_nx, busy_nx;
    logic             pick_a, any;

    rr_pick2 u_pick (
        .req_a  (req_a),
        .req_b  (req_b),
        .last_a (last_a),
        .pick_a (pick_a),
        .any    (any)
    );

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            last_a <= 1'b0;
            sel    <= SEL_B;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            mem_en <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            last_a <= last_a_nx;
            sel    <= sel_nx;
            gnt_a  <= gnt_a_nx;
            gnt_b  <= gnt_b_nx;
            done_a <= done_a_nx;
            done_b <= done_b_nx;
            mem_en <= mem_en_nx;
            busy   <= busy_nx;
        end
    end

    // Outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_nx  = state;
        cnt_nx    = cnt;
        last_a_nx = last_a;
        sel_nx    = sel;
        gnt_a_nx  = gnt_a;
        gnt_b_nx  = gnt_b;
        busy_nx   = busy;
        done_a_nx = 1'b0;
        done_b_nx = 1'b0;
        mem_en_nx = 1'b0;

        case (state)
            ISSUE: begin
                state_nx  = WAIT;
                done_a_nx = gnt_a && (cnt == '0);
                done_b_nx = gnt_b && (cnt == '0);
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    gnt_a_nx = 1'b0;
                    gnt_b_nx = 1'b0;
                    busy_nx  = 1'b0;
                end else begin
                    cnt_nx    = cnt - CNT_ONE;
                    done_a_nx = gnt_a && (cnt == CNT_ONE);
                    done_b_nx = gnt_b && (cnt == CNT_ONE);
                end
            end
            default: begin  // IDLE, and the unused encoding recovers here too
                gnt_a_nx = 1'b0;
                gnt_b_nx = 1'b0;
                busy_nx  = 1'b0;
                if (any) begin
                    state_nx  = ISSUE;
                    cnt_nx    = CNT_LOAD;
                    last_a_nx = pick_a;
                    sel_nx    = pick_a ? SEL_A : SEL_B;
                    gnt_a_nx  = pick_a;
                    gnt_b_nx  = ~pick_a;
                    mem_en_nx = 1'b1;
                    busy_nx   = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed plan plus random traffic against a transaction-timing model,
// for a MEM_LAT=2 instance and a MEM_LAT=1 instance with A requesting continuously.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0, req_a1 = 1'b0;
    logic gnt_a, gnt_b, done_a, done_b, sel, mem_en, busy;
    logic gnt_a1, gnt_b1, done_a1, done_b1, sel1, mem_en1, busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_men1 = -1;
    bit pg_a = 1'b0, pg_b = 1'b0;
    bit order[$];

    // Model per instance: a transaction issued in cycle t owns the port through t+lat,
    // strobes memory in t, completes in t+lat, and the port is idle again in t+lat+1.
    bit m_active [2];
    bit m_owner_a[2];
    int m_t      [2];
    bit m_last_a [2];
    bit m_sel    [2];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .sel(sel), .mem_en(mem_en), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a1), .req_b(1'b0),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .done_a(done_a1), .done_b(done_b1),
        .sel(sel1), .mem_en(mem_en1), .busy(busy1)
    );

    function automatic int lat(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic void model_step(int i, bit ra, bit rb, bit rst_ok);
        if (!rst_ok) begin
            m_active[i] = 1'b0;
            m_last_a[i] = 1'b0;
            m_sel[i]    = 1'b0;
        end else if (m_active[i]) begin
            if (cyc == m_t[i] + lat(i) + 1) m_active[i] = 1'b0;
        end else if (ra || rb) begin
            if (ra && rb) m_owner_a[i] = !m_last_a[i];
            else          m_owner_a[i] = ra;
            m_active[i] = 1'b1;
            m_t[i]      = cyc;
            m_last_a[i] = m_owner_a[i];
            m_sel[i]    = m_owner_a[i];
        end
    endfunction

    // {gnt_a, gnt_b, done_a, done_b, mem_en, busy, sel}
    function automatic logic [6:0] exp_vec(int i);
        bit act, oa, fin;
        act = m_active[i];
        oa  = m_owner_a[i];
        fin = act && (cyc == m_t[i] + lat(i));
        return {act && oa, act && !oa, fin && oa, fin && !oa,
                act && (cyc == m_t[i]), act, m_sel[i]};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step(0, req_a, req_b, rst_n);
        model_step(1, req_a1, 1'b0, rst_n);
        if (!rst_n) prev_men1 = -1;
        #1;
        check("outputs_lat2", {gnt_a, gnt_b, done_a, done_b, mem_en, busy, sel}, exp_vec(0));
        check("outputs_lat1", {gnt_a1, gnt_b1, done_a1, done_b1, mem_en1, busy1, sel1}, exp_vec(1));
        check("gnt_overlap", gnt_a & gnt_b, 0);
        if (mem_en1) begin
            if (prev_men1 >= 0) check("lat1_men_spacing", cyc - prev_men1, 3);
            prev_men1 = cyc;
        end
        if (done_a1) check("lat1_done_after_men", cyc - prev_men1, 1);
        if (gnt_a && !pg_a) order.push_back(1'b1);
        if (gnt_b && !pg_b) order.push_back(1'b0);
        pg_a = gnt_a;
        pg_b = gnt_b;
    endtask

    task automatic wait_done(bit for_a, int budget);
        int n = 0;
        while (!(for_a ? done_a : done_b) && n < budget) begin
            tick();
            n++;
        end
        check(for_a ? "wait_done_a" : "wait_done_b", for_a ? done_a : done_b, 1);
    endtask

    initial begin
        repeat (3) tick();
        rst_n  = 1'b1;
        req_a1 = 1'b1;
        tick();

        // A alone: issue in k+1, done in k+3, idle in k+4
        req_a = 1'b1;
        tick();
        check("a_issue", {sel, gnt_a, mem_en}, 3'b111);
        tick();
        check("a_wait_no_done", done_a, 0);
        tick();
        check("a_done_k3", done_a, 1);
        req_a = 1'b0;
        tick();
        check("a_idle_k4", {busy, gnt_a}, 2'b00);

        // Tie after reset: grants alternate starting with A
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        order.delete();
        req_a = 1'b1;
        req_b = 1'b1;
        for (int n = 0; n < 60 && order.size() < 4; n++) tick();
        check("tie_count", order.size(), 4);
        for (int i = 0; i < 4; i++) check("tie_order", order[i], (i % 2 == 0));
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (6) tick();

        // B alone, request dropped during WAIT: done still pulses, sel stays B
        req_b = 1'b1;
        tick();
        check("b_issue", {sel, gnt_b, mem_en}, 3'b011);
        tick();
        req_b = 1'b0;
        tick();
        check("b_done_k3", {done_b, sel}, 2'b10);
        repeat (2) tick();

        // Reset during A's WAIT: abandoned, last_a cleared so the next tie goes to A
        req_a = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        req_a = 1'b0;
        tick();
        check("rst_outputs", {gnt_a, gnt_b, done_a, done_b, mem_en, busy, sel}, 7'd0);
        rst_n = 1'b1;
        tick();
        check("rst_no_done", done_a, 0);
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        check("post_rst_tie_a", {gnt_a, gnt_b}, 2'b10);
        wait_done(1'b1, 10);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) tick();

        // A arrives during B's WAIT: granted two cycles after done_b
        req_b = 1'b1;
        tick();
        tick();
        req_a = 1'b1;
        wait_done(1'b0, 10);
        req_b = 1'b0;
        tick();
        check("a_not_yet", gnt_a, 0);
        tick();
        check("a_two_after_done_b", gnt_a, 1);
        wait_done(1'b1, 10);
        req_a = 1'b0;
        tick();

        // Random traffic with occasional drops and resets
        for (int i = 0; i < 400; i++) begin
            if (done_a || $urandom_range(0, 19) == 0) req_a = 1'b0;
            else if (!req_a) req_a = ($urandom_range(0, 2) == 0);
            if (done_b || $urandom_range(0, 19) == 0) req_b = 1'b0;
            else if (!req_b) req_b = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer for the single shared memory port of the KGP-RISC core. Arbitrates between requester A (load/store unit) and requester B (instruction fetch), drives the `sel` line of the address/write-data 2:1 muxes in front of the memory, issues a one-cycle memory enable, and times the fixed memory latency to return a completion pulse to the owner. Round-robin on contention, so neither side starves.

## Interface
- `MEM_LAT`, 2: cycles from the `mem_en` cycle to read data valid; legal range 1..7.
- `CNT_W`, 3: width of the latency counter; must satisfy 2^CNT_W > MEM_LAT.

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_a`  in  1  requester A (LSU) wants the port; held until `done_a`
- `req_b`  in  1  requester B (fetch) wants the port; held until `done_b`
- `gnt_a`  out  1  A owns the port (ISSUE through last WAIT cycle)
- `gnt_b`  out  1  B owns the port
- `done_a`  out  1  one-cycle pulse: A's transaction completes, memory data valid this cycle
- `done_b`  out  1  one-cycle pulse for B
- `sel`  out  1  mux select: 1 routes A, 0 routes B
- `mem_en`  out  1  one-cycle memory access strobe
- `busy`  out  1  high in ISSUE and WAIT

## Operation
- States: IDLE, ISSUE, WAIT. All outputs registered.
- IDLE: gnt_*, done_*, mem_en, busy low; `sel` holds its last value. Any request sampled at the edge selects a winner, loads `sel` and `last_a`, and moves to ISSUE.
- Winner:
  - only A → A; only B → B.
  - both → the side not served last. `last_a` = 1 after an A grant; it resets to 0, so A wins the first tie.
- ISSUE (exactly 1 cycle):
  - winner's gnt = 1, mem_en = 1, busy = 1.
  - counter loaded with MEM_LAT-1.
  - next state WAIT.
- WAIT:
  - gnt and busy held; mem_en = 0.
  - counter decrements each cycle.
  - in the cycle the counter reads 0: winner's done = 1, then return to IDLE with gnt dropped.
- Request dropped during ISSUE/WAIT: ignored; the transaction completes and done still pulses.
- `gnt_a` and `gnt_b` are never high together. `done_x` is high only while `gnt_x` is high.
- Requests are not sampled in ISSUE or WAIT. Re-arbitration occurs only from IDLE.

## Timing
- Reset values: gnt_a = gnt_b = done_a = done_b = mem_en = busy = 0, sel = 0, last_a = 0, counter = 0, state IDLE.
- Request sampled high at edge k (in IDLE):
  - ISSUE in cycle k+1, with sel valid in the same cycle as mem_en.
  - WAIT spans cycles k+2 .. k+1+MEM_LAT.
  - done in cycle k+1+MEM_LAT.
  - IDLE in cycle k+2+MEM_LAT.
- Occupancy per transaction is MEM_LAT+2 cycles including the IDLE cycle. Requesters deassert req the cycle after done; otherwise a new transaction starts from IDLE.
- Both requesting continuously: grants alternate A, B, A, B… Maximum wait for either side is one foreign transaction.
- Reset asserted mid-transaction: next edge forces the reset values. The transaction is abandoned with no done pulse, and `last_a` is cleared.
- MEM_LAT = 1: WAIT lasts one cycle, and done is coincident with the first WAIT cycle.

## Structure
- Shared package/include:
  - state encoding constants (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2)
  - `SEL_A = 1'b1`, `SEL_B = 1'b0`
- Unused encoding 2'd3 decodes to IDLE.
- One natural sub-module, `rr_pick2`: combinational 2-way round-robin picker; inputs req_a, req_b, last_a; outputs pick_a, any.
- Counter and FSM stay in the top.

## Test plan
- Reset, then `req_a` only with MEM_LAT = 2 → sel = 1, gnt_a = 1 and mem_en = 1 in cycle k+1; done_a in k+3; IDLE in k+4.
- `req_a` and `req_b` rise together after reset, held for four transactions → grant order A, B, A, B; gnt_* never overlap.
- `req_b` only, deasserted in the WAIT cycle → done_b still pulses at k+3; sel = 0 throughout.
- `rst_n` low during WAIT of an A transaction → next cycle all outputs 0 and sel = 0; no done_a; next tie goes to A.
- MEM_LAT = 1 build, `req_a` held continuously → mem_en every 3 cycles, each followed by done_a one cycle later.
- `req_a` rises during B's WAIT → A not granted until B's done; then gnt_a two cycles after done_b.
